// File: rtl/jtframe_dipbank_if.sv
// Download bus feeding the DIP bank: byte writes into the DIP region.
// master = download/OSD side, slave = DIP bank.
interface jtframe_dipbank_if #(
    parameter int AW = 4
) ();
    logic          dwn_en;
    logic          dwn_wr;
    logic [AW-1:0] dwn_addr;
    logic [7:0]    dwn_data;

    modport master (
        output dwn_en,
        output dwn_wr,
        output dwn_addr,
        output dwn_data
    );

    modport slave (
        input dwn_en,
        input dwn_wr,
        input dwn_addr,
        input dwn_data
    );
endinterface

// File: rtl/jtframe_dipbank.sv
// Multi-byte DIP bank: shadow writes applied at vblank, settle reset, frame pause.
// Optional checksum byte at address BANKS: define JTFRAME_DIPBANK_CHK_EN.
module jtframe_dipbank #(
    parameter int               BANKS   = 4,
    parameter int               AW      = 4,
    parameter logic [8*BANKS-1:0] DEFAULT = '1,
    parameter int               SETTLE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vb_i,
    input  logic                 game_pause_i,
    jtframe_dipbank_if.slave     dwn,
    output logic [8*BANKS-1:0]   dip_sw_o,
    output logic                 dip_upd_o,
    output logic                 dip_rst_o,
    output logic                 dip_pause_o,
    output logic                 busy_o,
    output logic                 chk_err_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PEND,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    state_t             state_q;
    logic [8*BANKS-1:0] shadow_q;
    logic [8*BANKS-1:0] dip_sw_q;
    logic               dirty_q;
    logic [CW-1:0]      cnt_q;
    logic               vb_l_q;
    logic               dip_upd_q;
    logic               dip_rst_q;
    logic               dip_pause_q;
    logic               chk_err_q;

    logic vb_edge_d;
    logic wr_ok_d;
    logic chk_ok_d;

    assign vb_edge_d = vb_i & ~vb_l_q;
    assign wr_ok_d   = dwn.dwn_en & dwn.dwn_wr
                     & (dwn.dwn_addr < AW'(BANKS));

`ifdef JTFRAME_DIPBANK_CHK_EN
    logic [7:0] chk_q;
    logic [7:0] sum_d;

    // Running byte sum of the shadow, compared on window close
    always_comb begin
        sum_d = 8'd0;
        for (int i = 0; i < BANKS; i++) begin
            sum_d = sum_d + shadow_q[i*8 +: 8];
        end
    end

    // Checksum byte sits just past the last bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 8'd0;
        end else if (dwn.dwn_en && dwn.dwn_wr
                     && dwn.dwn_addr == AW'(BANKS)) begin
            chk_q <= dwn.dwn_data;
        end
    end

    assign chk_ok_d = (sum_d == chk_q);
`else
    assign chk_ok_d = 1'b1;
`endif

    // Control FSM plus shadow/live registers and frame-synchronous pause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= DEFAULT;
            dip_sw_q    <= DEFAULT;
            dirty_q     <= 1'b0;
            cnt_q       <= '0;
            vb_l_q      <= 1'b0;
            dip_upd_q   <= 1'b0;
            dip_rst_q   <= 1'b0;
            dip_pause_q <= 1'b1;
            chk_err_q   <= 1'b0;
        end else begin
            vb_l_q    <= vb_i;
            dip_upd_q <= 1'b0;
            if (vb_edge_d) begin
                dip_pause_q <= ~game_pause_i;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (dwn.dwn_en) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!dwn.dwn_en) begin
                        if (!dirty_q) begin
                            state_q <= ST_IDLE;
                        end else if (!chk_ok_d) begin
                            // Bad download: roll shadow back to live
                            shadow_q  <= dip_sw_q;
                            dirty_q   <= 1'b0;
                            chk_err_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            state_q <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // A reopened window beats a same-cycle vblank
                    if (dwn.dwn_en) begin
                        state_q <= ST_LOAD;
                    end else if (vb_edge_d) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    dip_sw_q  <= shadow_q;
                    dirty_q   <= 1'b0;
                    chk_err_q <= 1'b0;
                    if (shadow_q != dip_sw_q) begin
                        dip_upd_q <= 1'b1;
                        dip_rst_q <= 1'b1;
                        cnt_q     <= CW'(SETTLE);
                        state_q   <= ST_SETTLE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (vb_edge_d) begin
                        if (cnt_q == CW'(1)) begin
                            dip_rst_q <= 1'b0;
                            cnt_q     <= '0;
                            if (dwn.dwn_en) begin
                                state_q <= ST_LOAD;
                            end else if (dirty_q) begin
                                state_q <= ST_PEND;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Writes land last so they win over APPLY clearing dirty
            for (int i = 0; i < BANKS; i++) begin
                if (wr_ok_d && dwn.dwn_addr == AW'(i)) begin
                    shadow_q[i*8 +: 8] <= dwn.dwn_data;
                end
            end
            if (wr_ok_d) begin
                dirty_q <= 1'b1;
            end
        end
    end

    assign dip_sw_o    = dip_sw_q;
    assign dip_upd_o   = dip_upd_q;
    assign dip_rst_o   = dip_rst_q;
    assign dip_pause_o = dip_pause_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign chk_err_o   = chk_err_q;

endmodule
